// File: rtl/parity_check_stage_pkg.sv
// +----------------------------------------------------------------------+
// | parity_check_stage_pkg : shared constants and parity helper          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package parity_check_stage_pkg;

    localparam int  PAR_EVEN = 0;
    localparam int  SUM_W    = 4;

    // Returns 1 when the three sum bits disagree with an even-parity word.
    function automatic logic parity3(input logic [2:0] i_bits);
        return (^i_bits) ^ 1'(PAR_EVEN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/parity_check_stage_sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter : up-counter with sync clear, saturating at all-ones     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/parity_check_stage.sv
// +----------------------------------------------------------------------+
// | parity_check_stage : checks adder parity, forwards good results,     |
// | requests retry on bad ones, counts errors and raises a sticky alarm  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module parity_check_stage
    import parity_check_stage_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int ALARM_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             c2,
    input  logic             p2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic             retry,
    output logic [CNT_W-1:0] err_cnt,
    output logic             alarm,
    input  logic             clr_alarm
);

    localparam int CONS_W = $clog2(ALARM_THRESH + 1);
    localparam logic [CONS_W-1:0] c_THRESH   = CONS_W'(ALARM_THRESH);
    localparam logic [CONS_W-1:0] c_THRESH_1 = CONS_W'(ALARM_THRESH - 1);

    logic             r_out_valid;
    logic [SUM_W-1:0] r_sum;
    logic             r_retry;
    logic             r_alarm;
    logic [CONS_W-1:0] w_consec;

    logic w_accept;
    logic w_mismatch;
    logic w_good_acc;
    logic w_bad_acc;
    logic w_cons_inc;
    logic w_cons_clr;
    logic w_cnt_inc;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_mismatch = parity3({s2, s1, s0}) != p2;
    assign w_good_acc = w_accept && !w_mismatch;
    assign w_bad_acc  = w_accept && w_mismatch;

    // Clear takes priority: an error in the clear cycle is not counted.
    assign w_cnt_inc  = w_bad_acc && !clr_alarm;
    assign w_cons_inc = w_cnt_inc && (w_consec != c_THRESH);
    assign w_cons_clr = clr_alarm || w_good_acc;

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cnt_inc),
        .clr   (clr_alarm),
        .q     (err_cnt)
    );

    sat_counter #(.W(CONS_W)) u_consec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cons_inc),
        .clr   (w_cons_clr),
        .q     (w_consec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
        end else if (w_good_acc) begin
            r_out_valid <= 1'b1;
            r_sum       <= {c2, s2, s1, s0};
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_retry <= w_bad_acc;
            if (clr_alarm) begin
                r_alarm <= 1'b0;
            end else if (w_bad_acc && (w_consec >= c_THRESH_1)) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum_out   = r_sum;
    assign retry     = r_retry;
    assign alarm     = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_parity_check_stage.sv
// +----------------------------------------------------------------------+
// | tb_parity_check_stage : directed vector bench for parity_check_stage |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_parity_check_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       s0, s1, s2, c2, p2;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sum_out;
    logic       retry;
    logic [3:0] err_cnt;
    logic       alarm;
    logic       clr_alarm;

    int n_checks = 0;
    int n_errors = 0;

    parity_check_stage #(.CNT_W(4), .ALARM_THRESH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .c2        (c2),
        .p2        (p2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .retry     (retry),
        .err_cnt   (err_cnt),
        .alarm     (alarm),
        .clr_alarm (clr_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [2:0] s;
        logic       c2;
        logic       p2;
        logic       ordy;
        logic       clr;
        logic       e_rdy;
        logic       e_ov;
        logic [3:0] e_sum;
        logic       e_retry;
        logic [3:0] e_cnt;
        logic       e_al;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [2:0] s, input logic cc,
                         input logic pp, input logic ordy, input logic clr);
        in_valid  = vld;
        {s2, s1, s0} = s;
        c2        = cc;
        p2        = pp;
        out_ready = ordy;
        clr_alarm = clr;
    endtask

    task automatic check_all(input string tag, input logic ov, input logic [3:0] sm,
                             input logic rt, input logic [3:0] cnt, input logic al);
        check({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, ov});
        check({tag, ".sum_out"},   sum_out,           sm);
        check({tag, ".retry"},     {3'b0, retry},     {3'b0, rt});
        check({tag, ".err_cnt"},   err_cnt,           cnt);
        check({tag, ".alarm"},     {3'b0, alarm},     {3'b0, al});
    endtask

    initial begin
        //            vld s       c2 p2 ordy clr | rdy ov sum     rt cnt   al
        vecs[0]  = '{1, 3'b101, 1, 0, 1, 0,   1, 1, 4'b1101, 0, 4'd0, 0};
        vecs[1]  = '{1, 3'b010, 0, 1, 1, 0,   1, 1, 4'b0010, 0, 4'd0, 0};
        vecs[2]  = '{0, 3'b000, 0, 0, 0, 0,   0, 1, 4'b0010, 0, 4'd0, 0};
        vecs[3]  = '{1, 3'b111, 1, 1, 0, 0,   0, 1, 4'b0010, 0, 4'd0, 0};
        vecs[4]  = '{1, 3'b111, 1, 1, 1, 0,   1, 1, 4'b1111, 0, 4'd0, 0};
        vecs[5]  = '{1, 3'b011, 0, 1, 1, 0,   1, 0, 4'b1111, 1, 4'd1, 0};
        vecs[6]  = '{1, 3'b001, 0, 1, 1, 0,   1, 1, 4'b0001, 0, 4'd1, 0};
        vecs[7]  = '{1, 3'b000, 0, 1, 1, 0,   1, 0, 4'b0001, 1, 4'd2, 0};
        vecs[8]  = '{1, 3'b110, 0, 1, 1, 0,   1, 0, 4'b0001, 1, 4'd3, 0};
        vecs[9]  = '{1, 3'b100, 0, 0, 1, 0,   1, 0, 4'b0001, 1, 4'd4, 1};
        vecs[10] = '{1, 3'b100, 0, 1, 1, 0,   1, 1, 4'b0100, 0, 4'd4, 1};
        vecs[11] = '{0, 3'b000, 0, 0, 1, 1,   1, 0, 4'b0100, 0, 4'd0, 0};
        vecs[12] = '{1, 3'b001, 0, 0, 1, 1,   1, 0, 4'b0100, 1, 4'd0, 0};
        vecs[13] = '{1, 3'b001, 0, 0, 1, 0,   1, 0, 4'b0100, 1, 4'd1, 0};
        vecs[14] = '{1, 3'b001, 0, 0, 1, 0,   1, 0, 4'b0100, 1, 4'd2, 0};
        vecs[15] = '{0, 3'b000, 0, 0, 1, 0,   1, 0, 4'b0100, 0, 4'd2, 0};

        // Reset held with random inputs
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        #1;
        check_all("reset", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        check("reset.in_ready", {3'b0, in_ready}, 4'h1);
        @(negedge clk);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].s, vecs[i].c2, vecs[i].p2, vecs[i].ordy, vecs[i].clr);
            #1;
            check($sformatf("v%0d.in_ready", i), {3'b0, in_ready}, {3'b0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_sum,
                      vecs[i].e_retry, vecs[i].e_cnt, vecs[i].e_al);
        end

        // 20 bad items: err_cnt saturates at 15, alarm set
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        @(posedge clk);
        #1;
        check_all("sat", 1'b0, 4'b0100, 1'b1, 4'd15, 1'b1);

        // Clear in the same cycle as a bad accept
        @(negedge clk);
        drive(1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_all("clr_bad", 1'b0, 4'b0100, 1'b1, 4'd0, 1'b0);

        // Good item held under backpressure, then async reset mid-transfer
        @(negedge clk);
        drive(1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("hold", 1'b1, 4'b1110, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midreset", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        check("midreset.retry", {3'b0, retry}, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
